// File: rtl/ip_arp_resolve.sv
// ip_arp_resolve: holds one IP packet (header plus payload stream) until the
// Ethernet MAC of its next hop is known, then forwards header, MAC and payload.
// The next hop is the destination IP for on-subnet or broadcast destinations,
// otherwise the gateway. Unresolved next hops are looked up through an ARP
// request/response port, with a per-attempt timeout and a bounded retry count.
// A packet whose next hop cannot be resolved has its payload drained and
// tx_error_arp_failed pulses.
// Optional feature: define IP_ARP_RESOLVE_CACHE_EN to add a one-entry
// {ip, mac} cache that skips ARP for a repeated next hop.
module ip_arp_resolve #(
  parameter int DATA_WIDTH      = 8,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int HDR_WIDTH       = 128,
  parameter int ARP_TIMEOUT     = 1024,
  parameter int ARP_RETRY_COUNT = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_ip_hdr_valid,
  output logic                  s_ip_hdr_ready,
  input  logic [HDR_WIDTH-1:0]  s_ip_hdr_data,
  input  logic [31:0]           s_ip_dest_ip,

  input  logic [DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
  input  logic                  s_ip_payload_axis_tvalid,
  output logic                  s_ip_payload_axis_tready,
  input  logic                  s_ip_payload_axis_tlast,
  input  logic                  s_ip_payload_axis_tuser,

  output logic                  m_ip_hdr_valid,
  input  logic                  m_ip_hdr_ready,
  output logic [HDR_WIDTH-1:0]  m_ip_hdr_data,
  output logic [31:0]           m_ip_dest_ip,
  output logic [47:0]           m_eth_dest_mac,

  output logic [DATA_WIDTH-1:0] m_ip_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_ip_payload_axis_tkeep,
  output logic                  m_ip_payload_axis_tvalid,
  input  logic                  m_ip_payload_axis_tready,
  output logic                  m_ip_payload_axis_tlast,
  output logic                  m_ip_payload_axis_tuser,

  output logic                  arp_request_valid,
  input  logic                  arp_request_ready,
  output logic [31:0]           arp_request_ip,

  input  logic                  arp_response_valid,
  output logic                  arp_response_ready,
  input  logic                  arp_response_error,
  input  logic [47:0]           arp_response_mac,

  input  logic [31:0]           local_ip,
  input  logic [31:0]           gateway_ip,
  input  logic [31:0]           subnet_mask,
  input  logic                  cache_clear,

  output logic                  busy,
  output logic                  tx_error_arp_failed
);

  localparam int TW = $clog2(ARP_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ARP_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(ARP_RETRY_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ARP_REQ,
    ARP_WAIT,
    SEND_HDR,
    XFER,
    DROP
  } state_t;

  state_t        state;
  logic          bcast_q;
  logic [TW-1:0] timeout_cnt;
  logic [3:0]    retry_cnt;

  // Next hop chosen from the live destination and configuration at accept time.
  logic [31:0] dest_next_hop;
  logic        dest_is_bcast;

  assign dest_is_bcast = (s_ip_dest_ip == 32'hFFFF_FFFF);
  assign dest_next_hop = dest_is_bcast                                   ? s_ip_dest_ip :
                         (((s_ip_dest_ip ^ local_ip) & subnet_mask) == '0) ? s_ip_dest_ip :
                                                                            gateway_ip;

  logic resp_fire;
  logic resp_ok;
  logic resp_err;
  logic timed_out;

  assign resp_fire = arp_response_valid && arp_response_ready;
  assign resp_ok   = resp_fire && !arp_response_error;
  assign resp_err  = resp_fire && arp_response_error;
  assign timed_out = (timeout_cnt == TIMEOUT_LAST);

  // Payload path: straight wires in XFER, sink-only in DROP, closed otherwise.
  logic in_xfer;
  logic in_drop;
  logic beat_last;

  assign in_xfer = (state == XFER);
  assign in_drop = (state == DROP);

  assign s_ip_payload_axis_tready = (in_xfer && m_ip_payload_axis_tready) || in_drop;
  assign m_ip_payload_axis_tvalid = in_xfer && s_ip_payload_axis_tvalid;
  assign m_ip_payload_axis_tdata  = in_xfer ? s_ip_payload_axis_tdata : '0;
  assign m_ip_payload_axis_tkeep  = in_xfer ? s_ip_payload_axis_tkeep : '0;
  assign m_ip_payload_axis_tlast  = in_xfer && s_ip_payload_axis_tlast;
  assign m_ip_payload_axis_tuser  = in_xfer && s_ip_payload_axis_tuser;

  assign beat_last = s_ip_payload_axis_tvalid && s_ip_payload_axis_tready &&
                     s_ip_payload_axis_tlast;

  // Header is accepted only in IDLE; rst is folded in so ready is low while reset is held.
  assign s_ip_hdr_ready = (state == IDLE) && !rst;
  assign busy           = (state != IDLE);

  logic        cache_hit;
  logic [47:0] cache_mac;

`ifdef IP_ARP_RESOLVE_CACHE_EN
  logic        cache_valid;
  logic [31:0] cache_ip;

  // One-entry cache: filled by a good ARP response, emptied by cache_clear.
  // NOTE: only the valid bit is reset; ip/mac are never read while invalid,
  // so giving them a reset value would add cost without changing behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
    end else if (cache_clear) begin
      cache_valid <= 1'b0;
    end else if (resp_ok) begin
      cache_valid <= 1'b1;
    end
  end

  // Cache payload written alongside the valid bit on a good response.
  always_ff @(posedge clk) begin
    if (resp_ok) begin
      cache_ip  <= arp_request_ip;
      cache_mac <= arp_response_mac;
    end
  end

  assign cache_hit = cache_valid && (cache_ip == arp_request_ip);
`else
  logic unused_cache_clear;

  assign unused_cache_clear = cache_clear;
  assign cache_hit          = 1'b0;
  assign cache_mac          = '0;
`endif

  // Resolution FSM with registered handshake outputs and latched packet context.
  // NOTE: every flop here is assigned with <= so each branch sees the values
  // from before the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      bcast_q             <= 1'b0;
      timeout_cnt         <= '0;
      retry_cnt           <= '0;
      m_ip_hdr_valid      <= 1'b0;
      m_ip_hdr_data       <= '0;
      m_ip_dest_ip        <= '0;
      m_eth_dest_mac      <= '0;
      arp_request_valid   <= 1'b0;
      arp_request_ip      <= '0;
      arp_response_ready  <= 1'b0;
      tx_error_arp_failed <= 1'b0;
    end else begin
      tx_error_arp_failed <= 1'b0;

      case (state)
        IDLE: begin
          if (s_ip_hdr_valid) begin
            m_ip_hdr_data  <= s_ip_hdr_data;
            m_ip_dest_ip   <= s_ip_dest_ip;
            arp_request_ip <= dest_next_hop;
            bcast_q        <= dest_is_bcast;
            state          <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (bcast_q) begin
            m_eth_dest_mac <= 48'hFFFF_FFFF_FFFF;
            m_ip_hdr_valid <= 1'b1;
            state          <= SEND_HDR;
          end else if (cache_hit) begin
            m_eth_dest_mac <= cache_mac;
            m_ip_hdr_valid <= 1'b1;
            state          <= SEND_HDR;
          end else begin
            retry_cnt         <= '0;
            arp_request_valid <= 1'b1;
            state             <= ARP_REQ;
          end
        end

        ARP_REQ: begin
          if (arp_request_ready) begin
            arp_request_valid  <= 1'b0;
            arp_response_ready <= 1'b1;
            timeout_cnt        <= '0;
            state              <= ARP_WAIT;
          end
        end

        ARP_WAIT: begin
          // A good response in the timeout cycle still counts as success.
          if (resp_ok) begin
            m_eth_dest_mac     <= arp_response_mac;
            arp_response_ready <= 1'b0;
            m_ip_hdr_valid     <= 1'b1;
            state              <= SEND_HDR;
          end else if (resp_err || timed_out) begin
            arp_response_ready <= 1'b0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt         <= retry_cnt + 4'd1;
              arp_request_valid <= 1'b1;
              state             <= ARP_REQ;
            end else begin
              tx_error_arp_failed <= 1'b1;
              state               <= DROP;
            end
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        SEND_HDR: begin
          if (m_ip_hdr_ready) begin
            m_ip_hdr_valid <= 1'b0;
            state          <= XFER;
          end
        end

        XFER: begin
          if (beat_last) begin
            state <= IDLE;
          end
        end

        DROP: begin
          if (beat_last) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_arp_resolve.sv
// Self-checking bench for ip_arp_resolve: directed scenarios plus randomized
// packets, compared against a next-hop / cache model written from the rules.
// Works with and without IP_ARP_RESOLVE_CACHE_EN defined.
module tb_ip_arp_resolve;

  localparam int DW = 8;
  localparam int KW = 1;
  localparam int HW = 128;
  localparam int TO = 16;
  localparam int RC = 2;

  logic          clk;
  logic          rst;
  logic          s_ip_hdr_valid;
  logic          s_ip_hdr_ready;
  logic [HW-1:0] s_ip_hdr_data;
  logic [31:0]   s_ip_dest_ip;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic          s_tuser;
  logic          m_ip_hdr_valid;
  logic          m_ip_hdr_ready;
  logic [HW-1:0] m_ip_hdr_data;
  logic [31:0]   m_ip_dest_ip;
  logic [47:0]   m_eth_dest_mac;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          m_tuser;
  logic          arp_request_valid;
  logic          arp_request_ready;
  logic [31:0]   arp_request_ip;
  logic          arp_response_valid;
  logic          arp_response_ready;
  logic          arp_response_error;
  logic [47:0]   arp_response_mac;
  logic [31:0]   local_ip;
  logic [31:0]   gateway_ip;
  logic [31:0]   subnet_mask;
  logic          cache_clear;
  logic          busy;
  logic          tx_error_arp_failed;

  ip_arp_resolve #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .HDR_WIDTH(HW),
    .ARP_TIMEOUT(TO), .ARP_RETRY_COUNT(RC)
  ) dut (
    .clk(clk), .rst(rst),
    .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
    .s_ip_hdr_data(s_ip_hdr_data), .s_ip_dest_ip(s_ip_dest_ip),
    .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
    .s_ip_payload_axis_tvalid(s_tvalid), .s_ip_payload_axis_tready(s_tready),
    .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
    .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
    .m_ip_hdr_data(m_ip_hdr_data), .m_ip_dest_ip(m_ip_dest_ip),
    .m_eth_dest_mac(m_eth_dest_mac),
    .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep),
    .m_ip_payload_axis_tvalid(m_tvalid), .m_ip_payload_axis_tready(m_tready),
    .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tuser(m_tuser),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
    .local_ip(local_ip), .gateway_ip(gateway_ip), .subnet_mask(subnet_mask),
    .cache_clear(cache_clear),
    .busy(busy), .tx_error_arp_failed(tx_error_arp_failed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

`ifdef IP_ARP_RESOLVE_CACHE_EN
  logic        mc_valid = 1'b0;
  logic [31:0] mc_ip    = '0;
  logic [47:0] mc_mac   = '0;
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_hop(input logic [31:0] d);
    if (d == 32'hFFFF_FFFF) return d;
    if (((d ^ local_ip) & subnet_mask) == 32'h0) return d;
    return gateway_ip;
  endfunction

  task automatic model_cache_clear();
`ifdef IP_ARP_RESOLVE_CACHE_EN
    mc_valid = 1'b0;
`endif
  endtask

  // mode: 0 good response after a random delay, 1 first response errors,
  // 2 never respond, 3 good response exactly in the timeout cycle.
  // abort_after >= 0 returns after that many payload beats (packet left in XFER).
  task automatic send_packet(input logic [31:0] dest, input int nbytes, input int mode,
                             input logic [47:0] rmac, input int abort_after);
    logic [HW-1:0] hdr;
    logic [31:0]   hop;
    logic [47:0]   exp_mac;
    logic          bcast, hit, exp_drop, got_err, done, req_hs, wait_now, hs, first, lst;
    int            exp_reqs, reqs, wait_cnt, resp_delay, idx;
    logic [DW-1:0] pay [$];
    logic          usr [$];

    hdr = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < nbytes; i++) begin
      pay.push_back(DW'($urandom));
      usr.push_back(1'($urandom));
    end
    bcast   = (dest == 32'hFFFF_FFFF);
    hop     = model_hop(dest);
    hit     = bcast;
    exp_mac = bcast ? 48'hFFFF_FFFF_FFFF : rmac;
`ifdef IP_ARP_RESOLVE_CACHE_EN
    if (!bcast && mc_valid && mc_ip == hop) begin
      hit     = 1'b1;
      exp_mac = mc_mac;
    end
`endif
    exp_drop = !hit && (mode == 2);
    exp_reqs = hit ? 0 : (mode == 1) ? 2 : (mode == 2) ? RC + 1 : 1;

    // Header accept (cycle N), then N+1 and N+2 observations.
    s_ip_hdr_data  = hdr;
    s_ip_dest_ip   = dest;
    s_ip_hdr_valid = 1'b1;
    chk("hdr_ready_idle", s_ip_hdr_ready, 1'b1);
    tick();
    s_ip_hdr_valid = 1'b0;
    s_ip_dest_ip   = $urandom;
    s_ip_hdr_data  = {$urandom, $urandom, $urandom, $urandom};
    chk("n1_state", {busy, s_ip_hdr_ready, m_ip_hdr_valid, arp_request_valid}, 4'b1000);
    tick();
    chk("n2_valids", {m_ip_hdr_valid, arp_request_valid}, hit ? 2'b10 : 2'b01);

    // ARP resolution phase.
    reqs = 0; wait_cnt = 0; resp_delay = 0; got_err = 1'b0; done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      arp_request_ready  = 1'b0;
      arp_response_valid = 1'b0;
      arp_response_error = 1'b0;
      if (m_ip_hdr_valid) begin
        done = 1'b1;
      end else if (tx_error_arp_failed) begin
        got_err = 1'b1;
        done    = 1'b1;
      end else begin
        if (arp_request_valid) begin
          chk("arp_ip", arp_request_ip, hop);
          arp_request_ready = 1'($urandom_range(0, 1));
        end
        if (arp_response_ready && mode != 2 && wait_cnt >= resp_delay) begin
          arp_response_valid = 1'b1;
          arp_response_error = (mode == 1) && (reqs == 1);
          arp_response_mac   = arp_response_error ? 48'hBAD0_BAD0_BAD0 : rmac;
        end
        req_hs   = arp_request_valid && arp_request_ready;
        wait_now = arp_response_ready;
        tick();
        if (wait_now) wait_cnt++;
        if (req_hs) begin
          if (reqs > 0 && mode == 2) chk("timeout_span", wait_cnt, TO);
          reqs++;
          wait_cnt   = 0;
          resp_delay = (mode == 3) ? TO - 1 : int'($urandom_range(0, TO - 1));
        end
      end
    end
    chk("resolved", done, 1'b1);
    chk("arp_requests", reqs, exp_reqs);
    chk("drop_pulse", got_err, exp_drop);
    if (exp_drop) chk("timeout_span_last", wait_cnt, TO);

`ifdef IP_ARP_RESOLVE_CACHE_EN
    if (!hit && !exp_drop) begin
      mc_valid = 1'b1;
      mc_ip    = hop;
      mc_mac   = rmac;
    end
`endif

    // Header out phase.
    if (!exp_drop) begin
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        m_ip_hdr_ready = 1'($urandom_range(0, 1));
        hs = m_ip_hdr_valid && m_ip_hdr_ready;
        if (hs) begin
          chk("out_mac", m_eth_dest_mac, exp_mac);
          chk("out_dest", m_ip_dest_ip, dest);
          chk("out_hdr", m_ip_hdr_data, hdr);
        end
        tick();
        if (hs) done = 1'b1;
      end
      m_ip_hdr_ready = 1'b0;
      chk("hdr_sent", done, 1'b1);
    end

    // Payload phase: forwarded intact, or drained with nothing emitted.
    idx = 0; first = 1'b1;
    for (int c = 0; c < 5000 && idx < nbytes && !(abort_after >= 0 && idx >= abort_after); c++) begin
      lst      = (idx == nbytes - 1);
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = pay[idx];
      s_tkeep  = '1;
      s_tlast  = lst;
      s_tuser  = usr[idx];
      m_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (exp_drop) begin
        chk("drop_tready", s_tready, 1'b1);
        chk("drop_mvalid", m_tvalid, 1'b0);
      end else begin
        chk("fwd_tvalid", m_tvalid, s_tvalid);
        chk("fwd_tready", s_tready, m_tready);
        if (m_tvalid && m_tready)
          chk("fwd_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, {pay[idx], 1'b1, lst, usr[idx]});
      end
      hs = s_tvalid && s_tready;
      tick();
      if (hs) idx++;
      if (first && exp_drop) chk("err_pulse_width", tx_error_arp_failed, 1'b0);
      first = 1'b0;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (abort_after < 0) begin
      chk("payload_beats", idx, nbytes);
      chk("idle_after", {busy, s_ip_hdr_ready}, 2'b01);
    end
  endtask

  initial begin
    logic [31:0] last_dest;
    logic [31:0] d;

    rst = 1'b1;
    s_ip_hdr_valid = 1'b0; s_ip_hdr_data = '0; s_ip_dest_ip = '0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_ip_hdr_ready = 1'b0; m_tready = 1'b0;
    arp_request_ready = 1'b0; arp_response_valid = 1'b0;
    arp_response_error = 1'b0; arp_response_mac = '0;
    local_ip = 32'h0A00_0001; subnet_mask = 32'hFFFF_FF00; gateway_ip = 32'h0A00_00FE;
    cache_clear = 1'b0;

    // Reset state.
    #2;
    chk("rst_outputs", {s_ip_hdr_ready, m_ip_hdr_valid, arp_request_valid, arp_response_ready,
                        busy, tx_error_arp_failed, s_tready, m_tvalid}, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {s_ip_hdr_ready, busy}, 2'b10);

    // On-subnet destination resolved by ARP, 64-byte payload.
    send_packet(32'h0A00_0005, 64, 0, 48'h02_00_00_00_00_05, -1);
    // Off-subnet destination goes to the gateway; first ARP answer is an error.
    send_packet(32'h0808_0808, 16, 1, 48'h02_AA_BB_CC_DD_EE, -1);
    // Broadcast: no ARP, all-ones MAC.
    send_packet(32'hFFFF_FFFF, 8, 0, 48'h0, -1);
    // No response at all: 1 + RC requests, error pulse, payload drained.
    send_packet(32'h0A00_0063, 10, 2, 48'h0, -1);
    // Response arrives in the timeout cycle and wins.
    send_packet(32'h0A00_0021, 4, 3, 48'h02_00_00_00_00_21, -1);

    // Same next hop twice, then cache_clear, then again.
    send_packet(32'h0A00_0007, 6, 0, 48'h02_00_00_00_00_07, -1);
    send_packet(32'h0A00_0007, 6, 0, 48'h02_00_00_00_00_07, -1);
    cache_clear = 1'b1;
    tick();
    cache_clear = 1'b0;
    model_cache_clear();
    send_packet(32'h0A00_0007, 6, 0, 48'h02_00_00_00_00_07, -1);

    // Randomized packets.
    last_dest = 32'h0A00_0007;
    for (int p = 0; p < 10; p++) begin
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFFF;
        1:       d = {24'h0A0000, 8'($urandom)};
        2:       d = $urandom;
        default: d = last_dest;
      endcase
      last_dest = d;
      send_packet(d, int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
                  {16'h0200, 32'($urandom)}, -1);
    end

    // Reset in the middle of a forwarded payload.
    send_packet(32'h0A00_0042, 20, 0, 48'h02_00_00_00_00_42, 5);
    s_tvalid = 1'b1; s_tdata = 8'h5A; s_tkeep = '1; m_tready = 1'b1;
    #1;
    chk("pre_rst_xfer", m_tvalid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valids", {m_ip_hdr_valid, m_tvalid, s_tready, s_ip_hdr_ready, arp_request_valid,
                           arp_response_ready, busy, tx_error_arp_failed}, 8'h00);
    chk("rst_mid_mac", m_eth_dest_mac, 48'h0);
    tick();
    rst = 1'b0;
    model_cache_clear();
    tick();
    chk("rst_remainder_held", {s_tready, busy, s_ip_hdr_ready}, 3'b001);
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    send_packet(32'h0A00_0042, 12, 0, 48'h02_00_00_00_00_43, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
